// File: rtl/crtc_pkg.sv
// Shared CRTC definitions: register indices, PET power-up register values,
// field widths, the raster state type and the HSYNC width decode.
package crtc_pkg;

  localparam int H_W        = 8;
  localparam int ROW_W      = 7;
  localparam int RA_W       = 5;
  localparam int ADJ_W      = 5;
  localparam int START_HI_W = 6;
  localparam int START_LO_W = 8;
  localparam int REG_IDX_W  = 5;
  localparam int HS_CNT_W   = 5;

  localparam logic [REG_IDX_W-1:0] R0_H_TOTAL     = 5'd0;
  localparam logic [REG_IDX_W-1:0] R1_H_DISPLAYED = 5'd1;
  localparam logic [REG_IDX_W-1:0] R2_HSYNC_POS   = 5'd2;
  localparam logic [REG_IDX_W-1:0] R3_SYNC_WIDTH  = 5'd3;
  localparam logic [REG_IDX_W-1:0] R4_V_TOTAL     = 5'd4;
  localparam logic [REG_IDX_W-1:0] R5_V_ADJUST    = 5'd5;
  localparam logic [REG_IDX_W-1:0] R6_V_DISPLAYED = 5'd6;
  localparam logic [REG_IDX_W-1:0] R7_VSYNC_POS   = 5'd7;
  localparam logic [REG_IDX_W-1:0] R8_INTERLACE   = 5'd8;
  localparam logic [REG_IDX_W-1:0] R9_MAX_SCAN    = 5'd9;
  localparam logic [REG_IDX_W-1:0] R10_CUR_START  = 5'd10;
  localparam logic [REG_IDX_W-1:0] R11_CUR_END    = 5'd11;
  localparam logic [REG_IDX_W-1:0] R12_START_HI   = 5'd12;
  localparam logic [REG_IDX_W-1:0] R13_START_LO   = 5'd13;

  // PET 40-column power-up values
  localparam logic [7:0] PET_R0  = 8'h31;
  localparam logic [7:0] PET_R1  = 8'h28;
  localparam logic [7:0] PET_R2  = 8'h29;
  localparam logic [7:0] PET_R3  = 8'h0F;
  localparam logic [7:0] PET_R4  = 8'h28;
  localparam logic [7:0] PET_R5  = 8'h05;
  localparam logic [7:0] PET_R6  = 8'h19;
  localparam logic [7:0] PET_R7  = 8'h21;
  localparam logic [7:0] PET_R8  = 8'h00;
  localparam logic [7:0] PET_R9  = 8'h07;
  localparam logic [7:0] PET_R10 = 8'h00;
  localparam logic [7:0] PET_R11 = 8'h00;
  localparam logic [7:0] PET_R12 = 8'h10;
  localparam logic [7:0] PET_R13 = 8'h00;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_ADJUST = 1'b1
  } crtc_state_e;

  // A programmed HSYNC width of 0 means 16 characters
  function automatic logic [HS_CNT_W-1:0] hsync_width(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction

endpackage

// File: rtl/crtc_sync_pulse.sv
// Load/countdown pulse generator. A trigger seen while idle loads the
// width; each step then counts down and the pulse is high while nonzero.
// Triggers arriving while a pulse is running are ignored, so a pulse is
// never cut short or stretched.
module crtc_sync_pulse #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             trig,
  input  logic [CNT_W-1:0] width,
  output logic             pulse
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;

  // Next count: decrement a running pulse, otherwise load on trigger
  always_comb begin
    count_d = count_q;
    if (step) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else if (trig) begin
        count_d = width;
      end
    end
    pulse_d = (count_d != '0);
  end

  // Counter and registered pulse output
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/crtc_timing.sv
// MC6845-style raster timing for the PET video path. Converts live CRTC
// register values into MA/RA, display enable and sync pulses. Every output
// is registered and describes the position just entered on a cclk_en edge.
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int VSYNC_LINES = 16,
  parameter int MA_WIDTH    = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cclk_en,
  input  logic [H_W-1:0]        r0_h_total,
  input  logic [H_W-1:0]        r1_h_displayed,
  input  logic [H_W-1:0]        r2_hsync_pos,
  input  logic [7:0]            r3_sync_width,
  input  logic [ROW_W-1:0]      r4_v_total,
  input  logic [ADJ_W-1:0]      r5_v_adjust,
  input  logic [ROW_W-1:0]      r6_v_displayed,
  input  logic [ROW_W-1:0]      r7_vsync_pos,
  input  logic [RA_W-1:0]       r9_max_scan,
  input  logic [START_HI_W-1:0] r12_start_hi,
  input  logic [START_LO_W-1:0] r13_start_lo,
  output logic [MA_WIDTH-1:0]   ma,
  output logic [RA_W-1:0]       ra,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync
);

  localparam int VS_CNT_W = $clog2(VSYNC_LINES + 1);

  crtc_state_e         state_q, state_d;
  logic                run_q, run_d;
  logic [H_W-1:0]      h_q, h_d;
  logic [RA_W-1:0]     ra_q, ra_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADJ_W-1:0]    adj_q, adj_d;
  logic [MA_WIDTH-1:0] row_start_q, row_start_d;
  logic [MA_WIDTH-1:0] ma_q, ma_d;
  logic                de_q, de_d;

  logic                eol;
  logic                new_frame;
  logic                line_start;
  logic                h_step, h_trig, v_trig;
  logic                adj_last;
  logic [MA_WIDTH-1:0] start_addr;
  logic [HS_CNT_W-1:0] hs_width;
  logic [3:0]          unused_r3_hi;

  assign start_addr   = MA_WIDTH'({r12_start_hi, r13_start_lo});
  assign hs_width     = hsync_width(r3_sync_width[3:0]);
  assign unused_r3_hi = r3_sync_width[7:4];
  // A live R5 of 0 while adjusting ends the adjust period at once
  assign adj_last = (r5_v_adjust == '0) ||
                    (({1'b0, adj_q} + 6'd1) >= {1'b0, r5_v_adjust});

  // Raster position, address and enable for the next character position
  always_comb begin
    run_d       = run_q;
    state_d     = state_q;
    h_d         = h_q;
    ra_d        = ra_q;
    row_d       = row_q;
    adj_d       = adj_q;
    row_start_d = row_start_q;
    ma_d        = ma_q;
    de_d        = de_q;
    eol         = 1'b0;
    new_frame   = 1'b0;
    line_start  = 1'b0;
    h_step      = 1'b0;
    h_trig      = 1'b0;
    v_trig      = 1'b0;
    if (cclk_en) begin
      h_step = 1'b1;
      if (!run_q) begin
        // First character after reset enters frame position 0 directly
        run_d     = 1'b1;
        new_frame = 1'b1;
      end else begin
        eol  = (h_q == r0_h_total);
        h_d  = eol ? '0 : h_q + 8'd1;
        ma_d = ma_q + MA_WIDTH'(1);
        // Next row starts where this row's displayed span ends
        if ((state_q == ST_ACTIVE) && (h_q == r1_h_displayed) && (ra_q == r9_max_scan)) begin
          row_start_d = ma_q;
        end
        if (eol) begin
          ma_d = row_start_d;
          if (state_q == ST_ACTIVE) begin
            if (ra_q == r9_max_scan) begin
              ra_d = '0;
              if (row_q == r4_v_total) begin
                if (r5_v_adjust == '0) begin
                  new_frame = 1'b1;
                end else begin
                  state_d = ST_ADJUST;
                  adj_d   = '0;
                end
              end else begin
                row_d = row_q + 7'd1;
              end
            end else begin
              ra_d = ra_q + 5'd1;
            end
          end else begin
            if (adj_last) begin
              new_frame = 1'b1;
            end else begin
              adj_d = adj_q + 5'd1;
              ra_d  = (ra_q == r9_max_scan) ? '0 : ra_q + 5'd1;
            end
          end
        end
      end
      // Frame restart overrides any row/scanline advance
      if (new_frame) begin
        state_d     = ST_ACTIVE;
        h_d         = '0;
        ra_d        = '0;
        row_d       = '0;
        adj_d       = '0;
        row_start_d = start_addr;
        ma_d        = start_addr;
      end
      line_start = new_frame || eol;
      h_trig     = (h_d == r2_hsync_pos);
      v_trig     = (state_d == ST_ACTIVE) && (row_d == r7_vsync_pos) && (ra_d == '0);
      de_d       = (h_d < r1_h_displayed) && (state_d == ST_ACTIVE) && (row_d < r6_v_displayed);
    end
  end

  // Raster state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACTIVE;
      run_q       <= 1'b0;
      h_q         <= '0;
      ra_q        <= '0;
      row_q       <= '0;
      adj_q       <= '0;
      row_start_q <= '0;
      ma_q        <= '0;
      de_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      h_q         <= h_d;
      ra_q        <= ra_d;
      row_q       <= row_d;
      adj_q       <= adj_d;
      row_start_q <= row_start_d;
      ma_q        <= ma_d;
      de_q        <= de_d;
    end
  end

  crtc_sync_pulse #(
    .CNT_W (HS_CNT_W)
  ) u_hsync (
    .clk   (clk),
    .reset (reset),
    .step  (h_step),
    .trig  (h_trig),
    .width (hs_width),
    .pulse (hsync)
  );

  crtc_sync_pulse #(
    .CNT_W (VS_CNT_W)
  ) u_vsync (
    .clk   (clk),
    .reset (reset),
    .step  (line_start),
    .trig  (v_trig),
    .width (VS_CNT_W'(VSYNC_LINES)),
    .pulse (vsync)
  );

  assign ma = ma_q;
  assign ra = ra_q;
  assign de = de_q;

endmodule
